// File: rtl/vit_decision_out.sv
// Viterbi survivor-decision stage: min-PM state select, warm-up gating,
// decoded-bit FIFO with valid/ready output and PM normalisation request.
module vit_decision_out #(
    parameter int TRACE_DEPTH = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int NORM_THRESH = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       sym_valid,
    input  logic [6:0] PM_0,
    input  logic [6:0] PM_1,
    input  logic [6:0] PM_2,
    input  logic [6:0] PM_3,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    input  logic [7:0] data_2,
    input  logic [7:0] data_3,
    output logic       dec_bit,
    output logic       dec_valid,
    input  logic       dec_ready,
    output logic       pm_norm,
    output logic [6:0] norm_val,
    output logic       overflow,
    output logic [1:0] best_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {WARM, RUN} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0] mem_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic            ovf_q;
    logic            pm_norm_q;
    logic [6:0]      norm_val_q;
    logic [1:0]      best_q;

    logic [6:0]      min_pm;
    logic [1:0]      best_idx;
    logic            cand_bit;
    logic            take;
    logic            push, pop, full, wr_en, ovf_set, norm_req;

    // Strict less-than keeps the lowest index on ties
    always_comb begin
        min_pm   = PM_0;
        best_idx = 2'd0;
        if (PM_1 < min_pm) begin
            min_pm   = PM_1;
            best_idx = 2'd1;
        end
        if (PM_2 < min_pm) begin
            min_pm   = PM_2;
            best_idx = 2'd2;
        end
        if (PM_3 < min_pm) begin
            min_pm   = PM_3;
            best_idx = 2'd3;
        end
        unique case (best_idx)
            2'd0:    cand_bit = data_0[7];
            2'd1:    cand_bit = data_1[7];
            2'd2:    cand_bit = data_2[7];
            default: cand_bit = data_3[7];
        endcase
    end

    assign take = sym_valid && !flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (flush) begin
            state_d = WARM;
            cnt_d   = 4'd0;
        end else if (sym_valid) begin
            unique case (state_q)
                WARM: begin
                    if (cnt_q == 4'(TRACE_DEPTH - 1)) state_d = RUN;
                    else cnt_d = cnt_q + 4'd1;
                end
                default: push = 1'b1;
            endcase
        end
    end

    assign dec_valid = (fcnt_q != '0);
    assign dec_bit   = dec_valid & mem_q[rd_ptr_q];
    assign full      = (fcnt_q == CW'(FIFO_DEPTH));
    assign pop       = dec_valid && dec_ready && !flush;
    // When full, a simultaneous pop frees the slot the push lands in
    assign wr_en     = push && (!full || pop);
    assign ovf_set   = push && full && !pop;
    assign norm_req  = take && (min_pm >= 7'(NORM_THRESH)) && !pm_norm_q;

    always_comb begin
        fcnt_d = fcnt_q;
        if (wr_en && !pop)      fcnt_d = fcnt_q + CW'(1);
        else if (!wr_en && pop) fcnt_d = fcnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WARM;
            cnt_q      <= 4'd0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            ovf_q      <= 1'b0;
            pm_norm_q  <= 1'b0;
            norm_val_q <= 7'd0;
            best_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pm_norm_q  <= norm_req;
            norm_val_q <= norm_req ? min_pm : 7'd0;
            if (take) best_q <= best_idx;
            if (ovf_set) ovf_q <= 1'b1;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                fcnt_q   <= '0;
            end else begin
                if (wr_en) begin
                    mem_q[wr_ptr_q] <= cand_bit;
                    wr_ptr_q        <= AW'(wr_ptr_q + 1'b1);
                end
                if (pop) rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
                fcnt_q <= fcnt_d;
            end
        end
    end

    assign pm_norm    = pm_norm_q;
    assign norm_val   = norm_val_q;
    assign overflow   = ovf_q;
    assign best_state = best_q;

endmodule

// File: tb/tb_vit_decision_out.sv
// Directed bench for vit_decision_out: warm-up, min/tie select, FIFO
// backpressure and overflow, normalisation pulses, flush and async reset.
module tb_vit_decision_out;

    logic       clk = 1'b0;
    logic       rst_n, flush, sym_valid, dec_ready;
    logic [6:0] PM_0, PM_1, PM_2, PM_3;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       dec_bit, dec_valid, pm_norm, overflow;
    logic [6:0] norm_val;
    logic [1:0] best_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vit_decision_out dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .sym_valid(sym_valid),
        .PM_0(PM_0), .PM_1(PM_1), .PM_2(PM_2), .PM_3(PM_3),
        .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .dec_bit(dec_bit), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .pm_norm(pm_norm), .norm_val(norm_val), .overflow(overflow),
        .best_state(best_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic [6:0] p0, p1, p2, p3,
                       input logic [7:0] d0, d1, d2, d3);
        PM_0 = p0; PM_1 = p1; PM_2 = p2; PM_3 = p3;
        data_0 = d0; data_1 = d1; data_2 = d2; data_3 = d3;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
    endtask

    // State 0 is best; its oldest survivor bit is b
    task automatic sym0(input logic b);
        sym(7'd0, 7'd10, 7'd10, 7'd10, {b, 7'h00}, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic pop_chk(input string tag, input logic b);
        chk({tag, "_v"}, 32'(dec_valid), 32'd1);
        chk({tag, "_b"}, 32'(dec_bit), 32'(b));
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic warm();
        for (int i = 0; i < 8; i++) sym0(1'b0);
    endtask

    initial begin
        flush = 0; sym_valid = 0; dec_ready = 0;
        PM_0 = 0; PM_1 = 0; PM_2 = 0; PM_3 = 0;
        data_0 = 0; data_1 = 0; data_2 = 0; data_3 = 0;
        rst_n = 1'b0;
        #2;
        chk("rst_bit", 32'(dec_bit), 32'd0);
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_norm", 32'(pm_norm), 32'd0);
        chk("rst_nval", 32'(norm_val), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_best", 32'(best_state), 32'd0);
        do_reset();

        // T1 warm-up
        for (int i = 0; i < 8; i++) begin
            sym0(1'b1);
            chk("t1_warm", 32'(dec_valid), 32'd0);
        end
        sym(7'd0, 7'd10, 7'd10, 7'd10, 8'h80, 8'h00, 8'h00, 8'h00);
        chk("t1_best", 32'(best_state), 32'd0);
        pop_chk("t1_first", 1'b1);
        chk("t1_empty", 32'(dec_valid), 32'd0);

        // T2 min / tie
        sym(7'd5, 7'd3, 7'd3, 7'd9, 8'h00, 8'h80, 8'h00, 8'h00);
        chk("t2_best1", 32'(best_state), 32'd1);
        pop_chk("t2_bit1", 1'b1);
        sym(7'd7, 7'd7, 7'd7, 7'd7, 8'h00, 8'h80, 8'h80, 8'h80);
        chk("t2_best0", 32'(best_state), 32'd0);
        pop_chk("t2_bit0", 1'b0);
        sym(7'd9, 7'd8, 7'd2, 7'd4, 8'h80, 8'h80, 8'h00, 8'h80);
        chk("t2_best2", 32'(best_state), 32'd2);
        pop_chk("t2_bit2", 1'b0);

        // T3 backpressure and overflow
        sym0(1'b1); sym0(1'b0); sym0(1'b1); sym0(1'b1);
        chk("t3_ovf4", 32'(overflow), 32'd0);
        sym0(1'b0);
        chk("t3_ovf5", 32'(overflow), 32'd1);
        tick();
        chk("t3_hold", 32'(dec_bit), 32'd1);
        pop_chk("t3_d1", 1'b1);
        pop_chk("t3_d2", 1'b0);
        pop_chk("t3_d3", 1'b1);
        pop_chk("t3_d4", 1'b1);
        chk("t3_empty", 32'(dec_valid), 32'd0);
        chk("t3_sticky", 32'(overflow), 32'd1);

        // T4 full push+pop
        do_reset();
        warm();
        sym0(1'b0); sym0(1'b1); sym0(1'b1); sym0(1'b0);
        dec_ready = 1'b1;
        sym0(1'b1);
        dec_ready = 1'b0;
        chk("t4_ovf", 32'(overflow), 32'd0);
        pop_chk("t4_d1", 1'b1);
        pop_chk("t4_d2", 1'b1);
        pop_chk("t4_d3", 1'b0);
        pop_chk("t4_d4", 1'b1);
        chk("t4_empty", 32'(dec_valid), 32'd0);

        // T5 normalisation
        sym(7'd110, 7'd100, 7'd120, 7'd127, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t5_p1", 32'(pm_norm), 32'd1);
        chk("t5_v1", 32'(norm_val), 32'd100);
        sym(7'd110, 7'd100, 7'd120, 7'd127, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t5_gap", 32'(pm_norm), 32'd0);
        sym(7'd110, 7'd100, 7'd120, 7'd127, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t5_p2", 32'(pm_norm), 32'd1);
        chk("t5_v2", 32'(norm_val), 32'd100);
        tick();
        chk("t5_one", 32'(pm_norm), 32'd0);
        sym(7'd95, 7'd100, 7'd120, 7'd127, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t5_below", 32'(pm_norm), 32'd0);

        // T6 flush with 4 bits queued, then warm-up again
        chk("t6_pre", 32'(dec_valid), 32'd1);
        flush = 1'b1;
        PM_0 = 7'd0; data_0 = 8'h80;
        sym_valid = 1'b1;
        tick();
        flush = 1'b0;
        sym_valid = 1'b0;
        chk("t6_flush", 32'(dec_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            sym0(1'b1);
            chk("t6_warm", 32'(dec_valid), 32'd0);
        end
        sym(7'd100, 7'd110, 7'd110, 7'd110, 8'h80, 8'h00, 8'h00, 8'h00);
        chk("t6_out", 32'(dec_valid), 32'd1);
        chk("t6_norm", 32'(pm_norm), 32'd1);

        // Async reset mid-burst
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(dec_valid), 32'd0);
        chk("ar_bit", 32'(dec_bit), 32'd0);
        chk("ar_norm", 32'(pm_norm), 32'd0);
        chk("ar_nval", 32'(norm_val), 32'd0);
        chk("ar_ovf", 32'(overflow), 32'd0);
        chk("ar_best", 32'(best_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
